// File: rtl/lut_search_arbiter.sv
// lut_search_arbiter
// Shares one combinational-read lookup-table ROM among NREQ requesters.
// A round-robin arbiter grants the ROM to one requester. The block then
// scans the table linearly for the first entry whose X field is >= the
// requester's key. It returns the bracketing pair (x0,y0)/(x1,y1) for
// downstream linear interpolation.
//
// Ports
//   clk       : clock
//   reset_n   : asynchronous active-low reset
//   req       : level request per requester, held until its done
//   req_key   : key per requester, slice i = [i*KEY_W +: KEY_W]
//   rom_addr  : registered ROM address
//   rom_data  : ROM entry at rom_addr (same cycle); X upper half, Y lower half
//   gnt       : one-hot grant, acceptance through done cycle
//   busy      : high while scanning and in the done cycle
//   done      : one-cycle pulse, results valid
//   done_id   : index of the served requester (held)
//   miss      : key above the X of the last entry (valid with done)
//   x0,y0,x1,y1 : bracketing entries, held until the next done
module lut_search_arbiter #(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned KEY_W  = 48,
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DEPTH  = 128
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*KEY_W-1:0] req_key,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [2*KEY_W-1:0]    rom_data,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            done_id,
  output logic                  miss,
  output logic [KEY_W-1:0]      x0,
  output logic [KEY_W-1:0]      y0,
  output logic [KEY_W-1:0]      x1,
  output logic [KEY_W-1:0]      y1
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [2:0]        r_last;
  logic [2:0]        r_idx;
  logic [KEY_W-1:0]  r_key;
  logic [KEY_W-1:0]  r_prev_x;
  logic [KEY_W-1:0]  r_prev_y;

  logic [KEY_W-1:0]  w_rom_x;
  logic [KEY_W-1:0]  w_rom_y;
  logic              w_hit;
  logic              w_at_end;
  logic              w_pick_valid;
  logic [2:0]        w_pick_idx;
  logic [NREQ-1:0]   w_pick_oh;
  logic [KEY_W-1:0]  w_pick_key;

  assign w_rom_x  = rom_data[2*KEY_W-1:KEY_W];
  assign w_rom_y  = rom_data[KEY_W-1:0];
  assign w_hit    = (w_rom_x >= r_key);
  assign w_at_end = (rom_addr == ADDR_W'(DEPTH - 1));

  // Round-robin pick. Each requester i gets a priority distance
  // (i - last - 1) mod NREQ, and the smallest distance among the active
  // requests wins. Indexing stays constant per unrolled iteration.
  always_comb begin : p_pick
    int unsigned best_d;
    int unsigned d;
    w_pick_valid = 1'b0;
    w_pick_idx   = '0;
    w_pick_oh    = '0;
    w_pick_key   = '0;
    best_d       = NREQ;
    d            = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      d = i + NREQ - 1 - 32'(r_last);
      if (d >= NREQ) d = d - NREQ;
      if (req[i] && (d < best_d)) begin
        best_d       = d;
        w_pick_valid = 1'b1;
        w_pick_idx   = 3'(i);
        w_pick_oh    = '0;
        w_pick_oh[i] = 1'b1;
        w_pick_key   = req_key[i*KEY_W +: KEY_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_last   <= 3'(NREQ - 1);
      r_idx    <= '0;
      r_key    <= '0;
      r_prev_x <= '0;
      r_prev_y <= '0;
      rom_addr <= '0;
      gnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      done_id  <= '0;
      miss     <= 1'b0;
      x0       <= '0;
      y0       <= '0;
      x1       <= '0;
      y1       <= '0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_pick_valid) begin
            r_idx    <= w_pick_idx;
            r_key    <= w_pick_key;
            gnt      <= w_pick_oh;
            rom_addr <= '0;
            busy     <= 1'b1;
            r_state  <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_hit) begin
            // A hit at entry 0 has no lower neighbour, so both ends clamp to it.
            if (rom_addr == '0) begin
              x0 <= w_rom_x;
              y0 <= w_rom_y;
            end else begin
              x0 <= r_prev_x;
              y0 <= r_prev_y;
            end
            x1      <= w_rom_x;
            y1      <= w_rom_y;
            miss    <= 1'b0;
            done    <= 1'b1;
            done_id <= r_idx;
            r_state <= S_DONE;
          end else if (w_at_end) begin
            x0      <= w_rom_x;
            y0      <= w_rom_y;
            x1      <= w_rom_x;
            y1      <= w_rom_y;
            miss    <= 1'b1;
            done    <= 1'b1;
            done_id <= r_idx;
            r_state <= S_DONE;
          end else begin
            r_prev_x <= w_rom_x;
            r_prev_y <= w_rom_y;
            rom_addr <= rom_addr + 1'b1;
          end
        end
        S_DONE: begin
          gnt     <= '0;
          busy    <= 1'b0;
          r_last  <= r_idx;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lut_search_arbiter.sv
// Testbench for lut_search_arbiter. It models the ROM as X_i=16*i and
// Y_i=1000-i. It predicts each bracket, the miss flag, the latency and the
// round-robin order from the table rule directly.
module tb_lut_search_arbiter;
  localparam int unsigned NREQ   = 2;
  localparam int unsigned KEY_W  = 48;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DEPTH  = 128;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*KEY_W-1:0] req_key = '0;
  logic [ADDR_W-1:0]     rom_addr;
  logic [2*KEY_W-1:0]    rom_data;
  logic [NREQ-1:0]       gnt;
  logic                  busy, done, miss;
  logic [2:0]            done_id;
  logic [KEY_W-1:0]      x0, y0, x1, y1;

  int vectors = 0;
  int miscompares = 0;
  int m_last = NREQ - 1;

  lut_search_arbiter #(.NREQ(NREQ), .KEY_W(KEY_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_key(req_key),
    .rom_addr(rom_addr), .rom_data(rom_data), .gnt(gnt), .busy(busy),
    .done(done), .done_id(done_id), .miss(miss),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1)
  );

  always #5 clk = ~clk;

  function automatic logic [KEY_W-1:0] tx(input int i);
    return KEY_W'(16 * i);
  endfunction

  function automatic logic [KEY_W-1:0] ty(input int i);
    return KEY_W'(1000 - i);
  endfunction

  always_comb rom_data = {tx(int'(rom_addr)), ty(int'(rom_addr))};

  // First entry with 16*i >= key is i = ceil(key/16); none if that is past the table.
  task automatic ref_lookup(input logic [KEY_W-1:0] key, output int lat, output logic m,
                            output logic [KEY_W-1:0] ex0, output logic [KEY_W-1:0] ey0,
                            output logic [KEY_W-1:0] ex1, output logic [KEY_W-1:0] ey1);
    longint unsigned i;
    i = (longint'(key) + 15) / 16;
    if (i >= DEPTH) begin
      m = 1'b1; lat = DEPTH + 1;
      ex0 = tx(DEPTH - 1); ey0 = ty(DEPTH - 1); ex1 = ex0; ey1 = ey0;
    end else begin
      m = 1'b0; lat = int'(i) + 2;
      ex1 = tx(int'(i)); ey1 = ty(int'(i));
      if (i == 0) begin ex0 = ex1; ey0 = ey1; end
      else begin ex0 = tx(int'(i) - 1); ey0 = ty(int'(i) - 1); end
    end
  endtask

  function automatic int model_pick(input int last, input logic [NREQ-1:0] m);
    for (int k = 1; k <= NREQ; k++)
      if (m[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic wait_done(input int budget, output int n, output bit timeout);
    n = 0; timeout = 1'b1;
    while (n < budget) begin
      @(negedge clk); n++;
      if (done === 1'b1) begin timeout = 1'b0; break; end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    vectors++;
    if ({rom_addr, gnt, busy, done, done_id, miss} !== '0) begin
      miscompares++;
      $display("FAIL reset_ctrl: addr=%0d gnt=%b busy=%b done=%b id=%0d miss=%b, expected all 0",
               rom_addr, gnt, busy, done, done_id, miss);
    end
    vectors++;
    if ({x0, y0, x1, y1} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: x0=%0d y0=%0d x1=%0d y1=%0d, expected all 0", x0, y0, x1, y1);
    end
    reset_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || gnt !== '0) begin
      miscompares++;
      $display("FAIL idle_after_reset: busy=%b gnt=%b, expected 0/0", busy, gnt);
    end
  endtask

  task automatic test_lookup(input int r, input logic [KEY_W-1:0] key);
    int lat, n; bit to; logic em;
    logic [KEY_W-1:0] e0, f0, e1, f1;
    logic [NREQ-1:0] eg;
    ref_lookup(key, lat, em, e0, f0, e1, f1);
    eg = '0; eg[r] = 1'b1;
    @(negedge clk);
    req_key[r*KEY_W +: KEY_W] = key;
    req = '0; req[r] = 1'b1;
    wait_done(DEPTH + 20, n, to);
    vectors++;
    if (to || n != lat) begin
      miscompares++;
      $display("FAIL lookup_latency r=%0d key=%0d: got %0d cycles (timeout=%0d), expected %0d",
               r, key, n, to, lat);
    end
    vectors++;
    if (done_id !== 3'(r)) begin
      miscompares++;
      $display("FAIL lookup_id key=%0d: got %0d, expected %0d", key, done_id, r);
    end
    vectors++;
    if ({miss, x0, y0, x1, y1} !== {em, e0, f0, e1, f1}) begin
      miscompares++;
      $display("FAIL lookup_data key=%0d: got miss=%b x0=%0d y0=%0d x1=%0d y1=%0d, expected miss=%b x0=%0d y0=%0d x1=%0d y1=%0d",
               key, miss, x0, y0, x1, y1, em, e0, f0, e1, f1);
    end
    vectors++;
    if (gnt !== eg || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL lookup_grant key=%0d: gnt=%b busy=%b, expected gnt=%b busy=1", key, gnt, busy, eg);
    end
    req = '0;
    m_last = r;
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || gnt !== '0 || busy !== 1'b0 || {x0, y0, x1, y1} !== {e0, f0, e1, f1}) begin
      miscompares++;
      $display("FAIL lookup_release key=%0d: done=%b gnt=%b busy=%b x0=%0d x1=%0d, expected 0/0/0 with held x0=%0d x1=%0d",
               key, done, gnt, busy, x0, x1, e0, e1);
    end
  endtask

  task automatic test_directed;
    test_lookup(0, 85);
    test_lookup(1, 0);
    test_lookup(1, 16);
    test_lookup(0, 3000);
    test_lookup(1, 2032);
    test_lookup(0, 2033);
  endtask

  task automatic test_random;
    for (int it = 0; it < 16; it++)
      test_lookup(int'($urandom_range(0, NREQ - 1)), KEY_W'($urandom_range(0, 2100)));
  endtask

  task automatic test_back_to_back;
    logic [KEY_W-1:0] keys [NREQ];
    int exp, lat, n; bit to, twohot; logic em;
    logic [KEY_W-1:0] e0, f0, e1, f1;
    for (int i = 0; i < NREQ; i++) keys[i] = KEY_W'($urandom_range(0, 600));
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) req_key[i*KEY_W +: KEY_W] = keys[i];
    req = '1;
    for (int s = 0; s < 4; s++) begin
      exp = model_pick(m_last, req);
      ref_lookup(keys[exp], lat, em, e0, f0, e1, f1);
      n = 0; to = 1'b1; twohot = 1'b0;
      while (n < DEPTH + 20) begin
        @(negedge clk); n++;
        if (!$onehot0(gnt)) twohot = 1'b1;
        if (done === 1'b1) begin to = 1'b0; break; end
      end
      vectors++;
      if (to || n != (s == 0 ? lat : lat + 1)) begin
        miscompares++;
        $display("FAIL rr_latency service=%0d: got %0d cycles (timeout=%0d), expected %0d",
                 s, n, to, (s == 0 ? lat : lat + 1));
      end
      vectors++;
      if (done_id !== 3'(exp) || twohot) begin
        miscompares++;
        $display("FAIL rr_order service=%0d: got id=%0d twohot=%b, expected id=%0d twohot=0",
                 s, done_id, twohot, exp);
      end
      vectors++;
      if ({miss, x0, y0, x1, y1} !== {em, e0, f0, e1, f1}) begin
        miscompares++;
        $display("FAIL rr_data service=%0d: got x0=%0d x1=%0d miss=%b, expected x0=%0d x1=%0d miss=%b",
                 s, x0, x1, miss, e0, e1, em);
      end
      m_last = exp;
    end
    req = '0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || gnt !== '0) begin
      miscompares++;
      $display("FAIL rr_release: busy=%b gnt=%b, expected 0/0", busy, gnt);
    end
  endtask

  task automatic test_reset_mid;
    int n; bit to, seen;
    test_lookup(0, 10);
    @(negedge clk);
    req_key[0 +: KEY_W] = 3000;
    req = 'b1;
    n = 0; seen = 1'b0;
    while (n < 100) begin
      @(negedge clk); n++;
      if (busy === 1'b1 && rom_addr === ADDR_W'(40)) begin seen = 1'b1; break; end
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL reset_mid_reach: rom_addr=%0d after %0d cycles, expected 40", rom_addr, n);
    end
    reset_n = 1'b0;
    req = '0;
    #1;
    vectors++;
    if ({rom_addr, gnt, busy, done, done_id, miss, x0, y0, x1, y1} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_clear: addr=%0d gnt=%b busy=%b done=%b x0=%0d, expected all 0",
               rom_addr, gnt, busy, done, x0);
    end
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL reset_mid_quiet: done/busy seen during reset, expected none");
    end
    reset_n = 1'b1;
    m_last = NREQ - 1;
    // Pointer back at NREQ-1: requester 0 wins a simultaneous request.
    @(negedge clk);
    req_key[0 +: KEY_W] = 85;
    req_key[KEY_W +: KEY_W] = 85;
    req = '1;
    wait_done(DEPTH + 20, n, to);
    vectors++;
    if (to || n != 8 || done_id !== 3'(model_pick(m_last, 2'b11))) begin
      miscompares++;
      $display("FAIL reset_mid_rr: got id=%0d after %0d cycles (timeout=%0d), expected id=%0d after 8",
               done_id, n, to, model_pick(m_last, 2'b11));
    end
    req = '0;
    m_last = model_pick(m_last, 2'b11);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    m_last = NREQ - 1;
    test_lookup(1, KEY_W'($urandom_range(0, 2100)));
  endtask

  task automatic test_drop;
    int n1, n2; bit to, reached, regrant;
    @(negedge clk);
    req_key[0 +: KEY_W] = 85;
    req = 'b1;
    n1 = 0; reached = 1'b0;
    while (n1 < 20) begin
      @(negedge clk); n1++;
      if (busy === 1'b1 && rom_addr === ADDR_W'(3)) begin reached = 1'b1; break; end
    end
    req = '0;
    wait_done(DEPTH + 20, n2, to);
    vectors++;
    if (!reached || to || n1 + n2 != 8) begin
      miscompares++;
      $display("FAIL drop_latency: got %0d cycles (reached=%b timeout=%0d), expected 8", n1 + n2, reached, to);
    end
    vectors++;
    if ({done_id, miss, x0, y0, x1, y1} !== {3'd0, 1'b0, tx(5), ty(5), tx(6), ty(6)}) begin
      miscompares++;
      $display("FAIL drop_data: got id=%0d miss=%b x0=%0d y0=%0d x1=%0d y1=%0d, expected 0 0 80 995 96 994",
               done_id, miss, x0, y0, x1, y1);
    end
    m_last = 0;
    regrant = 1'b0;
    @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      if (gnt !== '0 || busy !== 1'b0) regrant = 1'b1;
    end
    vectors++;
    if (regrant) begin
      miscompares++;
      $display("FAIL drop_no_regrant: gnt=%b busy=%b after release, expected no grant", gnt, busy);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_drop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
